// File: rtl/nn_run_ctrl.sv
// Inference sequencer for the binary NN engine: loads input bits into X bank 0,
// runs the compute engine under a watchdog, then streams result bits out.
module nn_run_ctrl #(
    parameter int X_ADDR_LEN  = 10,
    parameter int X_SEL_LEN   = 2,
    parameter int IN_LEN      = 2,
    parameter int OUT_LEN     = 2,
    parameter int OUT_SEL     = 0,
    parameter int RUN_CNT_LEN = 16,
    parameter int MAX_RUN     = 65535
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  err_timeout,
    input  logic                  in_valid,
    input  logic                  in_bit,
    output logic                  in_ready,
    output logic                  out_valid,
    output logic                  out_bit,
    input  logic                  out_ready,
    output logic                  cm_en,
    input  logic                  cm_finish,
    input  logic [X_ADDR_LEN-1:0] cm_x_addr,
    input  logic [X_SEL_LEN-1:0]  cm_x_sel,
    input  logic                  cm_x_wq,
    input  logic                  cm_wx_write,
    output logic [X_ADDR_LEN-1:0] x_addr,
    output logic [X_SEL_LEN-1:0]  x_sel,
    output logic                  x_wq,
    output logic                  x_wdata,
    input  logic                  x_rdata
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_LOAD_WAIT = 4'd1;
    localparam logic [3:0] S_LOAD_WR1  = 4'd2;
    localparam logic [3:0] S_LOAD_WR2  = 4'd3;
    localparam logic [3:0] S_LOAD_WR3  = 4'd4;
    localparam logic [3:0] S_RUN       = 4'd5;
    localparam logic [3:0] S_RD_ADDR   = 4'd6;
    localparam logic [3:0] S_RD_WAIT   = 4'd7;
    localparam logic [3:0] S_RD_CAP    = 4'd8;
    localparam logic [3:0] S_OUT_HOLD  = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;

    localparam logic [X_ADDR_LEN-1:0]  IN_LAST  = X_ADDR_LEN'(IN_LEN - 1);
    localparam logic [X_ADDR_LEN-1:0]  OUT_LAST = X_ADDR_LEN'(OUT_LEN - 1);
    localparam logic [X_SEL_LEN-1:0]   SEL_OUT  = X_SEL_LEN'(OUT_SEL);
    localparam logic [RUN_CNT_LEN-1:0] RUN_LAST = RUN_CNT_LEN'(MAX_RUN - 1);

    logic [3:0]             state;
    logic [X_ADDR_LEN-1:0]  cnt;
    logic [RUN_CNT_LEN-1:0] run_cnt;
    logic [X_ADDR_LEN-1:0]  ctl_addr;
    logic [X_SEL_LEN-1:0]   ctl_sel;
    logic                   ctl_wdata;

    assign busy     = (state != S_IDLE);
    assign in_ready = (state == S_LOAD_WAIT);

    // The engine owns the X port only while it is running.
    always_comb begin
        x_addr  = ctl_addr;
        x_sel   = ctl_sel;
        x_wq    = (state == S_LOAD_WR2);
        x_wdata = ctl_wdata;
        if (state == S_RUN) begin
            x_addr  = cm_x_addr;
            x_sel   = cm_x_sel;
            x_wq    = cm_x_wq;
            x_wdata = cm_wx_write;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            run_cnt     <= '0;
            ctl_addr    <= '0;
            ctl_sel     <= '0;
            ctl_wdata   <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            out_valid   <= 1'b0;
            out_bit     <= 1'b0;
            cm_en       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        err_timeout <= 1'b0;
                        cnt         <= '0;
                        state       <= S_LOAD_WAIT;
                    end
                end
                S_LOAD_WAIT: begin
                    if (in_valid) begin
                        ctl_sel   <= '0;
                        ctl_addr  <= cnt;
                        ctl_wdata <= in_bit;
                        state     <= S_LOAD_WR1;
                    end
                end
                S_LOAD_WR1: state <= S_LOAD_WR2;
                S_LOAD_WR2: state <= S_LOAD_WR3;
                S_LOAD_WR3: begin
                    if (cnt == IN_LAST) begin
                        cnt     <= '0;
                        run_cnt <= '0;
                        cm_en   <= 1'b1;
                        state   <= S_RUN;
                    end else begin
                        cnt   <= cnt + 1'b1;
                        state <= S_LOAD_WAIT;
                    end
                end
                S_RUN: begin
                    if (run_cnt != '1) run_cnt <= run_cnt + 1'b1;
                    // A finish on the last watchdog cycle still counts as success.
                    if (cm_finish) begin
                        cm_en <= 1'b0;
                        state <= S_RD_ADDR;
                    end else if (run_cnt == RUN_LAST) begin
                        err_timeout <= 1'b1;
                        cm_en       <= 1'b0;
                        state       <= S_DONE;
                    end
                end
                S_RD_ADDR: begin
                    ctl_sel  <= SEL_OUT;
                    ctl_addr <= cnt;
                    state    <= S_RD_WAIT;
                end
                S_RD_WAIT: state <= S_RD_CAP;
                S_RD_CAP: begin
                    out_bit   <= x_rdata;
                    out_valid <= 1'b1;
                    state     <= S_OUT_HOLD;
                end
                S_OUT_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (cnt == OUT_LAST) begin
                            state <= S_DONE;
                        end else begin
                            cnt   <= cnt + 1'b1;
                            state <= S_RD_ADDR;
                        end
                    end
                end
                S_DONE: begin
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/nn_run_ctrl.md
Name: nn_run_ctrl

Overview:
- Top-level sequencer for one inference of the binary NN compute engine (XNOR/popcount layers, X activation banks selected by x_sel).
- Streams the input image into X bank 0, then hands the X memory port to the compute engine by raising its `en`, and waits for `compute_finish`.
- Then reads the result bits back out of bank OUT_SEL and presents them on a valid/ready stream.
- Owns the X memory port mux: controller drives it in every state except RUN; the compute engine drives it during RUN.

Parameters:
- X_ADDR_LEN, 10, X memory address width
- X_SEL_LEN, 2, X bank select width
- IN_LEN, 2, number of input bits loaded into bank 0
- OUT_LEN, 2, number of result bits read from bank OUT_SEL
- OUT_SEL, 0, bank holding final results
- RUN_CNT_LEN, 16, width of the RUN watchdog counter
- MAX_RUN, 65535, RUN cycles before timeout (must be < 2^RUN_CNT_LEN)

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  asynchronous reset, active-low
- start  in  1  request one inference; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on entering IDLE from DONE
- err_timeout  out  1  sticky; set on watchdog expiry, cleared by accepted start
- in_valid  in  1  input bit valid
- in_bit  in  1  input bit
- in_ready  out  1  high only in LOAD_WAIT
- out_valid  out  1  result bit valid
- out_bit  out  1  result bit
- out_ready  in  1  result consumer ready
- cm_en  out  1  compute engine enable (0 = engine held in reset)
- cm_finish  in  1  compute engine done flag
- cm_x_addr  in  X_ADDR_LEN  engine X address
- cm_x_sel  in  X_SEL_LEN  engine bank select
- cm_x_wq  in  1  engine write strobe
- cm_wx_write  in  1  engine write data
- x_addr  out  X_ADDR_LEN  X memory address (muxed)
- x_sel  out  X_SEL_LEN  X bank select (muxed)
- x_wq  out  1  X write strobe (muxed)
- x_wdata  out  1  X write data (muxed)
- x_rdata  in  1  X read data, valid one cycle after address/sel are stable

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; cnt=0; run_cnt=0. Every output is 0: busy, done, err_timeout, in_ready, out_valid, out_bit, cm_en, x_wq, x_wdata, x_addr, x_sel. Reset mid-operation aborts immediately and cm_en drops the same instant.
- Port mux: in RUN, x_addr/x_sel/x_wq/x_wdata = cm_x_addr/cm_x_sel/cm_x_wq/cm_wx_write, combinationally. In all other states they come from controller registers. Controller x_wq is 0 outside LOAD_WR2.
- IDLE: on start=1, clear err_timeout, cnt=0, go to LOAD_WAIT. A start while busy is ignored.
- LOAD_WAIT: in_ready=1. On in_valid&in_ready, register x_sel=0, x_addr=cnt, x_wdata=in_bit, then go to LOAD_WR1.
- LOAD_WR1 (wq=0) -> LOAD_WR2 (wq=1) -> LOAD_WR3 (wq=0). This is a 3-cycle write with address and data stable around the strobe.
- LOAD_WR3 exit:
  - if cnt==IN_LEN-1: cnt=0, run_cnt=0, cm_en<=1, go to RUN;
  - else cnt++, go to LOAD_WAIT.
  - Minimum cost is 4 cycles per input bit.
- RUN: cm_en=1; run_cnt increments every cycle.
  - cm_finish=1: cm_en<=0, go to RD_ADDR.
  - else if run_cnt==MAX_RUN-1: err_timeout<=1, cm_en<=0, go to DONE with no readout.
  - If both occur in the same cycle, finish wins.
- RD_ADDR: x_sel=OUT_SEL, x_addr=cnt, go to RD_WAIT.
- RD_WAIT: wait one cycle for read latency, go to RD_CAP.
- RD_CAP: out_bit<=x_rdata, out_valid<=1, go to OUT_HOLD.
- OUT_HOLD: out_valid and out_bit held stable until out_ready=1. On handshake:
  - out_valid<=0;
  - if cnt==OUT_LEN-1, go to DONE;
  - else cnt++, go to RD_ADDR.
  - If out_ready is already high on entry, the handshake completes that cycle.
- DONE: busy=1, go to IDLE; done pulses for exactly 1 cycle on that transition.
- Counters: cnt is X_ADDR_LEN wide; IN_LEN and OUT_LEN must be ≤ 2^X_ADDR_LEN. run_cnt saturates and never wraps.

Test Plan:
- Load/run/read: start, feed bits 1,0 with in_valid held high. Expect bank0 writes addr0=1 and addr1=0, each with wq high for exactly 1 cycle. cm_en rises after the second write. Stub asserts cm_finish after 20 cycles; memory model holds 1,1 at OUT_SEL. Expect out stream 1,1, then done pulse, busy=0.
- Backpressure: during the load, gap in_valid for 5 cycles -> no write strobes and in_ready stays high. During readout, hold out_ready=0 for 7 cycles -> out_valid and out_bit stable, cnt unchanged.
- Port mux: in RUN, drive cm_x_addr=5, cm_x_sel=2, cm_x_wq=1 -> the x_* outputs mirror them the same cycle. Outside RUN the cm_* inputs have no effect on x_*.
- Timeout: MAX_RUN=10, cm_finish never asserted -> cm_en high exactly 10 cycles, err_timeout=1, no out_valid, done pulses. A subsequent start clears err_timeout.
- Simultaneous: cm_finish=1 on cycle MAX_RUN-1 -> readout proceeds and err_timeout stays 0. A start asserted while busy is ignored.
- Async reset: pull rst low mid-RUN and mid-OUT_HOLD, between clock edges -> cm_en, out_valid and busy go 0 immediately. After release the block is in IDLE and a fresh inference completes normally.
